pipe_ctrl: RTL

Pipeline hazard and sequencing controller for the five-stage RV32I core. It takes register-read addresses and FENCE detection from id, load/jump status from ex, and bus-wait requests from the memory side. From these it generates hold and flush controls for pc, if_id and id_ex, and it forwards the redirect target to pc. Stall decisions, jump flush extension and FENCE draining are all arbitrated here.

---
 rtl/pipe_ctrl_pkg.sv | 18 +
 rtl/pipe_ctrl_hazard_detect.sv | 23 ++
 rtl/pipe_ctrl.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg -- shared defines for the pipeline controller.
//   ZeroReg / ZeroWord : x0 register address and all-zero data word
//   pc_state_e         : controller FSM encodings (exported on state_o)
package pipe_ctrl_pkg;

  localparam logic [4:0]  ZeroReg  = 5'd0;
  localparam logic [31:0] ZeroWord = 32'd0;

  localparam int CNT_W = 3;

  typedef enum logic [2:0] {
    PC_RUN      = 3'd0,
    PC_BUS_WAIT = 3'd1,
    PC_FLUSH    = 3'd2,
    PC_DRAIN    = 3'd3
  } pc_state_e;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// hazard_detect -- combinational load-use comparator.
//   reg1_raddr_i, reg2_raddr_i : source registers of the instruction in id
//   ex_rd_i, ex_is_load_i      : destination / load flag of the instruction in ex
//   load_use_o                 : id needs a value the load in ex has not produced yet
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] reg1_raddr_i,
  input  logic [4:0] reg2_raddr_i,
  input  logic [4:0] ex_rd_i,
  input  logic       ex_is_load_i,
  output logic       load_use_o
);

  logic w_rs1_hit;
  logic w_rs2_hit;

  // x0 is never a real dependency, neither as source nor as destination.
  assign w_rs1_hit  = (reg1_raddr_i != ZeroReg) && (reg1_raddr_i == ex_rd_i);
  assign w_rs2_hit  = (reg2_raddr_i != ZeroReg) && (reg2_raddr_i == ex_rd_i);
  assign load_use_o = ex_is_load_i && (ex_rd_i != ZeroReg) && (w_rs1_hit || w_rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- hazard and sequencing controller for the five-stage RV32I core.
// Arbitrates, in priority order, bus stalls, taken jumps, load-use stalls and
// FENCE draining, and drives hold/flush for pc, if_id and id_ex.
//   clk, rst                       : core clock, asynchronous active-low reset
//   reg1_raddr_i, reg2_raddr_i     : id source registers (ZeroReg = unused)
//   fence_i                        : id holds a FENCE
//   ex_rd_i, ex_is_load_i          : ex destination and load flag
//   jump_flag_i, jump_addr_i       : ex taken branch/jump and its target
//   bus_req_i, bus_ack_i           : pending memory access / completes this cycle
//   hold_*_o, flush_*_o            : stage register freeze / NOP insert
//   jump_flag_o, jump_addr_o       : redirect to pc
//   state_o                        : FSM state (debug)
// Optional: define PIPE_CTRL_PERF_EN to add stall_cnt_o / flush_cnt_o, 32-bit
// wrapping counts of cycles with any hold / any flush asserted.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int JUMP_FLUSH_CYCLES = 1,  // 0..7
  parameter int DRAIN_CYCLES      = 3   // 1..7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  reg1_raddr_i,
  input  logic [4:0]  reg2_raddr_i,
  input  logic        fence_i,
  input  logic [4:0]  ex_rd_i,
  input  logic        ex_is_load_i,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic        bus_req_i,
  input  logic        bus_ack_i,
  output logic        hold_pc_o,
  output logic        hold_if_id_o,
  output logic        hold_id_ex_o,
  output logic        flush_if_id_o,
  output logic        flush_id_ex_o,
  output logic        jump_flag_o,
  output logic [31:0] jump_addr_o,
`ifdef PIPE_CTRL_PERF_EN
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o,
`endif
  output logic [2:0]  state_o
);

  localparam logic [CNT_W-1:0] JUMP_CNT  = CNT_W'(JUMP_FLUSH_CYCLES);
  localparam logic [CNT_W-1:0] DRAIN_CNT = CNT_W'(DRAIN_CYCLES - 1);

  pc_state_e        r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_fence_pass, w_fence_pass_nxt;

  logic w_load_use;
  logic w_bus_stall;
  logic w_run_like;
  logic w_fence_stall;

  hazard_detect u_hazard_detect (
    .reg1_raddr_i (reg1_raddr_i),
    .reg2_raddr_i (reg2_raddr_i),
    .ex_rd_i      (ex_rd_i),
    .ex_is_load_i (ex_is_load_i),
    .load_use_o   (w_load_use)
  );

  assign w_bus_stall   = bus_req_i & ~bus_ack_i;
  // The ack cycle of BUS_WAIT releases the pipeline, so it is arbitrated
  // exactly like RUN; otherwise a jump held in ex during the stall would
  // slip past when id_ex advances.
  assign w_run_like    = (r_state == PC_RUN) || (r_state == PC_BUS_WAIT);
  assign w_fence_stall = fence_i & ~r_fence_pass;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= PC_RUN;
      r_cnt        <= '0;
      r_fence_pass <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_fence_pass <= w_fence_pass_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_fence_pass_nxt = r_fence_pass;
    if (w_bus_stall) begin
      // Everything freezes; only RUN records that it is waiting.
      if (r_state == PC_RUN) w_state_nxt = PC_BUS_WAIT;
    end else begin
      unique case (r_state)
        PC_RUN, PC_BUS_WAIT: begin
          w_state_nxt      = PC_RUN;
          w_fence_pass_nxt = 1'b0;  // pass lasts a single RUN cycle
          if (jump_flag_i) begin
            if (JUMP_FLUSH_CYCLES > 0) begin
              w_cnt_nxt   = JUMP_CNT;
              w_state_nxt = PC_FLUSH;
            end
          end else if (w_load_use) begin
            // stall for this cycle only; no state change
          end else if (w_fence_stall) begin
            if (DRAIN_CYCLES > 1) begin
              w_cnt_nxt   = DRAIN_CNT;
              w_state_nxt = PC_DRAIN;
            end else begin
              w_fence_pass_nxt = 1'b1;
            end
          end
        end
        PC_FLUSH: begin
          w_cnt_nxt = r_cnt - 1'b1;
          if (r_cnt <= 1) w_state_nxt = PC_RUN;
        end
        PC_DRAIN: begin
          if (jump_flag_i) begin
            // The FENCE itself is being flushed, so the drain is abandoned.
            w_fence_pass_nxt = 1'b0;
            if (JUMP_FLUSH_CYCLES > 0) begin
              w_cnt_nxt   = JUMP_CNT;
              w_state_nxt = PC_FLUSH;
            end else begin
              w_state_nxt = PC_RUN;
            end
          end else begin
            w_cnt_nxt = r_cnt - 1'b1;
            if (r_cnt <= 1) begin
              w_state_nxt      = PC_RUN;
              w_fence_pass_nxt = 1'b1;
            end
          end
        end
        default: begin
          w_state_nxt      = PC_RUN;
          w_cnt_nxt        = '0;
          w_fence_pass_nxt = 1'b0;
        end
      endcase
    end
  end

  // Output logic: zero-latency, and forced to zero while reset is held.
  always_comb begin
    hold_pc_o     = 1'b0;
    hold_if_id_o  = 1'b0;
    hold_id_ex_o  = 1'b0;
    flush_if_id_o = 1'b0;
    flush_id_ex_o = 1'b0;
    jump_flag_o   = 1'b0;
    jump_addr_o   = ZeroWord;
    state_o       = 3'd0;
    if (rst) begin
      state_o = r_state;
      if (w_bus_stall) begin
        hold_pc_o    = 1'b1;
        hold_if_id_o = 1'b1;
        hold_id_ex_o = 1'b1;
      end else if ((w_run_like || (r_state == PC_DRAIN)) && jump_flag_i) begin
        jump_flag_o   = 1'b1;
        jump_addr_o   = jump_addr_i;
        flush_if_id_o = 1'b1;
        flush_id_ex_o = 1'b1;
      end else if (r_state == PC_FLUSH) begin
        flush_if_id_o = 1'b1;
      end else if ((r_state == PC_DRAIN) ||
                   (w_run_like && (w_load_use || w_fence_stall))) begin
        // Load-use, fence entry and drain all insert a bubble into id_ex.
        hold_pc_o     = 1'b1;
        hold_if_id_o  = 1'b1;
        flush_id_ex_o = 1'b1;
      end
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (hold_pc_o | hold_if_id_o | hold_id_ex_o) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (flush_if_id_o | flush_id_ex_o)           r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;
`endif

endmodule
